vscale_htif_pcr_responder: RTL

//  Core-side responder for the HTIF PCR request/response interface. The host issues CSR reads/writes on

---
 rtl/vscale_htif_pcr_responder.sv | 112 +++++++++++
 1 files changed

// File: rtl/vscale_htif_pcr_responder.sv
// Core-side HTIF PCR responder servicing host CSR accesses to tohost/fromhost.
// Optional: define HTIF_FROMHOST_IRQ_EN to add the registered fromhost_irq output.
module vscale_htif_pcr_responder #(
    parameter int          PCR_W       = 64,
    parameter int          XPR_W       = 32,
    parameter logic [11:0] ADDR_TOHOST = 12'h780,
    parameter logic [11:0] ADDR_FRHOST = 12'h781
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             htif_pcr_req_valid,
    output logic             htif_pcr_req_ready,
    input  logic             htif_pcr_req_rw,
    input  logic [11:0]      htif_pcr_req_addr,
    input  logic [PCR_W-1:0] htif_pcr_req_data,
    output logic             htif_pcr_resp_valid,
    input  logic             htif_pcr_resp_ready,
    output logic [PCR_W-1:0] htif_pcr_resp_data,
    input  logic             core_tohost_wen,
    input  logic [XPR_W-1:0] core_tohost_wdata,
    input  logic             core_fromhost_wen,
    input  logic [XPR_W-1:0] core_fromhost_wdata,
    output logic [XPR_W-1:0] core_tohost_rdata,
`ifdef HTIF_FROMHOST_IRQ_EN
    output logic [XPR_W-1:0] core_fromhost_rdata,
    output logic             fromhost_irq
`else
    output logic [XPR_W-1:0] core_fromhost_rdata
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [XPR_W-1:0] tohost_q, tohost_d;
    logic [XPR_W-1:0] fromhost_q, fromhost_d;
    logic [PCR_W-1:0] resp_data_q, resp_data_d;

    logic accept;
    logic hit_tohost;
    logic hit_fromhost;
    logic unused_req_data_hi;

    assign unused_req_data_hi = ^htif_pcr_req_data[PCR_W-1:XPR_W];

    assign accept       = htif_pcr_req_valid && (state_q == IDLE);
    assign hit_tohost   = (htif_pcr_req_addr == ADDR_TOHOST);
    assign hit_fromhost = (htif_pcr_req_addr == ADDR_FRHOST);

    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        tohost_d    = tohost_q;
        fromhost_d  = fromhost_q;

        case (state_q)
            IDLE: if (accept) state_d = RESP;
            RESP: if (htif_pcr_resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Response always carries the pre-access register value; tohost clears on host read.
        if (accept) begin
            if (hit_tohost) begin
                resp_data_d = {{(PCR_W-XPR_W){1'b0}}, tohost_q};
                tohost_d    = htif_pcr_req_rw ? htif_pcr_req_data[XPR_W-1:0] : '0;
            end else if (hit_fromhost) begin
                resp_data_d = {{(PCR_W-XPR_W){1'b0}}, fromhost_q};
                if (htif_pcr_req_rw) fromhost_d = htif_pcr_req_data[XPR_W-1:0];
            end else begin
                resp_data_d = '0;
            end
        end

        // Core writes take priority over any host-side effect on the same edge.
        if (core_tohost_wen)   tohost_d   = core_tohost_wdata;
        if (core_fromhost_wen) fromhost_d = core_fromhost_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tohost_q    <= '0;
            fromhost_q  <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            tohost_q    <= tohost_d;
            fromhost_q  <= fromhost_d;
            resp_data_q <= resp_data_d;
        end
    end

`ifdef HTIF_FROMHOST_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= (fromhost_q != '0);
    end

    assign fromhost_irq = irq_q;
`endif

    assign htif_pcr_req_ready  = (state_q == IDLE);
    assign htif_pcr_resp_valid = (state_q == RESP);
    assign htif_pcr_resp_data  = resp_data_q;
    assign core_tohost_rdata   = tohost_q;
    assign core_fromhost_rdata = fromhost_q;

endmodule
